rs_branch_sched: RTL and testbench
==================================

# rs_branch_sched

Branch reservation station and issue scheduler that sits in front of `fu_branch`. It holds dispatched BNE/JALR micro-ops until their physical source registers are ready. It selects the oldest ready entry in program order and issues it while the FU reports ready. On a branch mispredict it squashes every entry younger than the mispredicting branch.

## Interface
Parameters:
- DEPTH, 4, number of RS entries (power of two, 2..8)
- ROB_W, 5, ROB index width
- PREG_W, 7, physical register tag width

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry available; dispatch accepted when disp_valid && disp_ready
- disp_opcode / disp_func3  in  7 / 3  instruction opcode, func3
- disp_pc / disp_imm  in  32 / 32  instruction PC, sign-extended immediate
- disp_pd / disp_ps1 / disp_ps2  in  PREG_W each  dest and source physical tags
- disp_ps1_rdy / disp_ps2_rdy  in  1 each  source already valid in PRF
- disp_rob  in  ROB_W  ROB index of the micro-op
- wb_valid / wb_tag  in  1 / PREG_W  CDB wakeup broadcast
- rob_head  in  ROB_W  oldest in-flight ROB index (age reference)
- fu_ready  in  1  fu_b_ready from `fu_branch`
- mispredict / mispredict_tag  in  1 / ROB_W  from `fu_branch` output
- issued  out  1  issue strobe to `fu_branch` (drives its `issued` input)
- iss_opcode, iss_func3, iss_pc, iss_imm, iss_pd, iss_ps1, iss_ps2, iss_rob  out  as dispatch widths  issued entry fields
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Entry state: valid, ps1_rdy, ps2_rdy, plus all dispatch fields.
- Reset: all entries invalid. count=0, disp_ready=1, issued=0, all iss_* = 0.
- Dispatch: writes the lowest-index free entry at posedge.
  - Source ready = disp_psN_rdy OR (wb_valid && wb_tag==disp_psN) in the same cycle.
- disp_ready = (count < DEPTH) && !mispredict. A free made by a same-cycle issue is not reusable that cycle.
- Wakeup: a valid entry with psN==wb_tag while wb_valid sets psN_rdy at posedge. There is no same-cycle bypass into select.
- Age: age(x) = (x − rob_head) mod 2^ROB_W, unsigned ROB_W-bit subtraction. Smaller age is older. ROB indices in the RS are unique.
- Select (combinational): among valid entries with both sources ready, pick the one with minimum age.
- Issue:
  - issued = fu_ready && !mispredict && candidate exists.
  - iss_* carry the candidate's fields. When issued=0, iss_* hold 0.
  - The issued entry is invalidated at the same posedge.
- Squash: when mispredict=1, every valid entry with age(rob) > age(mispredict_tag) is invalidated at posedge. Entries with equal or smaller age are kept.
  - No issue and no dispatch occur in a mispredict cycle.
- count is registered and updated at posedge: +1 on dispatch, −1 on issue, −(number squashed) on mispredict.
- Simultaneous wakeup and issue select: the wakeup takes effect next cycle only.
- Reset asserted mid-operation overrides dispatch, wakeup, issue and squash.

## Timing
- Dispatch at edge N makes the entry visible at cycle N+1. The earliest issued=1 is cycle N+1, if both sources were ready at dispatch.
- Wakeup at cycle N allows issue at cycle N+1 at the earliest.
- issued is combinational in cycle N. `fu_branch` samples it at posedge N+1 and produces its result in cycle N+1.
- Throughput: one issue per cycle while fu_ready=1.
- A mispredict flagged in cycle N blocks issue in cycle N. Squashed entries are gone from cycle N+1.

## Test plan
- Reset: hold reset 1 cycle → count=0, disp_ready=1, issued=0, iss_pc=0.
- Basic issue:
  - Stimulus: dispatch BNE (opcode 1100011, func3 001, pc=2000, imm=100, rob=12, both sources ready), fu_ready=1.
  - Response: next cycle issued=1, iss_pc=2000, iss_rob=12. The cycle after, count=0 and issued=0.
- Wakeup:
  - Stimulus: dispatch JALR with ps1=7 not ready. Pulse wb_valid with wb_tag=7 at cycle N.
  - Response: issued=0 through cycle N, issued=1 at N+1 with iss_ps1=7.
- Age order with wrap:
  - Stimulus: rob_head=30, fu_ready=0, dispatch rob=2 then rob=31, both ready. Raise fu_ready.
  - Response: rob 31 issues first, rob 2 in the next cycle.
- Squash:
  - Stimulus: rob_head=0, entries rob 4, 6, 9, all unready. Mispredict with mispredict_tag=5, fu_ready=1.
  - Response: issued=0 that cycle, and next cycle count=1 with only rob 4 remaining.
- Full / mispredict dispatch block:
  - Stimulus: fill 4 entries, fu_ready=0, then assert disp_valid.
  - Response: disp_ready=0, count stays 4.
  - Stimulus: with count<4, assert disp_valid and mispredict together.
  - Response: disp_ready=0 and nothing is written.

Source files
------------

// File: rtl/rs_branch_sched.sv
// rs_branch_sched: reservation station and issue scheduler for the branch FU.
// Holds BNE/JALR micro-ops until both physical sources are ready, issues the
// oldest ready one (age relative to rob_head) and squashes younger entries
// on a mispredict.
module rs_branch_sched #(
  parameter int DEPTH  = 4,
  parameter int ROB_W  = 5,
  parameter int PREG_W = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [6:0]                disp_opcode,
  input  logic [2:0]                disp_func3,
  input  logic [31:0]               disp_pc,
  input  logic [31:0]               disp_imm,
  input  logic [PREG_W-1:0]         disp_pd,
  input  logic [PREG_W-1:0]         disp_ps1,
  input  logic [PREG_W-1:0]         disp_ps2,
  input  logic                      disp_ps1_rdy,
  input  logic                      disp_ps2_rdy,
  input  logic [ROB_W-1:0]          disp_rob,
  input  logic                      wb_valid,
  input  logic [PREG_W-1:0]         wb_tag,
  input  logic [ROB_W-1:0]          rob_head,
  input  logic                      fu_ready,
  input  logic                      mispredict,
  input  logic [ROB_W-1:0]          mispredict_tag,
  output logic                      issued,
  output logic [6:0]                iss_opcode,
  output logic [2:0]                iss_func3,
  output logic [31:0]               iss_pc,
  output logic [31:0]               iss_imm,
  output logic [PREG_W-1:0]         iss_pd,
  output logic [PREG_W-1:0]         iss_ps1,
  output logic [PREG_W-1:0]         iss_ps2,
  output logic [ROB_W-1:0]          iss_rob,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [ROB_W-1:0]  rob;
  } entry_t;

  // Entry storage
  entry_t            ent_reg [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  ps1_rdy_reg;
  logic [DEPTH-1:0]  ps2_rdy_reg;
  logic [CW-1:0]     count_reg;

  // Per-entry derived signals
  logic [ROB_W-1:0]  age [DEPTH];
  logic [DEPTH-1:0]  rdy_vec;
  logic [DEPTH-1:0]  wb_hit1;
  logic [DEPTH-1:0]  wb_hit2;
  logic [DEPTH-1:0]  squash_vec;
  logic [ROB_W-1:0]  mp_age;

  // Control
  logic              dispatch_fire;
  logic              disp_ps1_rdy_eff;
  logic              disp_ps2_rdy_eff;
  logic [IW-1:0]     free_idx;
  logic [IW-1:0]     sel_idx;
  logic              cand_found;
  logic [ROB_W-1:0]  best_age;
  logic [CW-1:0]     squash_cnt;
  logic [CW-1:0]     count_next;

  assign mp_age = mispredict_tag - rob_head;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Age is modulo distance from the ROB head, so wrap-around orders correctly.
      assign age[gi]        = ent_reg[gi].rob - rob_head;
      assign rdy_vec[gi]    = valid_reg[gi] & ps1_rdy_reg[gi] & ps2_rdy_reg[gi];
      assign wb_hit1[gi]    = wb_valid && (ent_reg[gi].ps1 == wb_tag);
      assign wb_hit2[gi]    = wb_valid && (ent_reg[gi].ps2 == wb_tag);
      assign squash_vec[gi] = mispredict && valid_reg[gi] && (age[gi] > mp_age);
    end
  endgenerate

  // A slot freed by this cycle's issue is deliberately not offered until next cycle.
  assign disp_ready    = (count_reg < DEPTH_C) && !mispredict;
  assign dispatch_fire = disp_valid && disp_ready;
  assign count         = count_reg;

  // A source broadcast on the CDB in the dispatch cycle must not be missed.
  assign disp_ps1_rdy_eff = disp_ps1_rdy || (wb_valid && (wb_tag == disp_ps1));
  assign disp_ps2_rdy_eff = disp_ps2_rdy || (wb_valid && (wb_tag == disp_ps2));

  // Lowest-index free slot for dispatch.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_reg[i]) free_idx = IW'(i);
    end
  end

  // Oldest ready entry; wakeups are registered so this sees last cycle's readiness.
  always_comb begin
    cand_found = 1'b0;
    sel_idx    = '0;
    best_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_vec[i] && (!cand_found || (age[i] < best_age))) begin
        cand_found = 1'b1;
        sel_idx    = IW'(i);
        best_age   = age[i];
      end
    end
  end

  assign issued = fu_ready && !mispredict && cand_found;

  // Issue fields are zeroed whenever nothing is issued.
  always_comb begin
    iss_opcode = '0;
    iss_func3  = '0;
    iss_pc     = '0;
    iss_imm    = '0;
    iss_pd     = '0;
    iss_ps1    = '0;
    iss_ps2    = '0;
    iss_rob    = '0;
    if (issued) begin
      iss_opcode = ent_reg[sel_idx].opcode;
      iss_func3  = ent_reg[sel_idx].func3;
      iss_pc     = ent_reg[sel_idx].pc;
      iss_imm    = ent_reg[sel_idx].imm;
      iss_pd     = ent_reg[sel_idx].pd;
      iss_ps1    = ent_reg[sel_idx].ps1;
      iss_ps2    = ent_reg[sel_idx].ps2;
      iss_rob    = ent_reg[sel_idx].rob;
    end
  end

  // Occupancy bookkeeping; dispatch and issue never coincide with a squash.
  always_comb begin
    squash_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash_cnt = squash_cnt + CW'(squash_vec[i]);
    end
    count_next = count_reg + CW'(dispatch_fire) - CW'(issued) - squash_cnt;
  end

  // Entry state update: dispatch write, wakeup, issue invalidate, squash.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg   <= '0;
      ps1_rdy_reg <= '0;
      ps2_rdy_reg <= '0;
      count_reg   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i] <= '0;
      end
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (dispatch_fire && (free_idx == IW'(i))) begin
          valid_reg[i]      <= 1'b1;
          ps1_rdy_reg[i]    <= disp_ps1_rdy_eff;
          ps2_rdy_reg[i]    <= disp_ps2_rdy_eff;
          ent_reg[i].opcode <= disp_opcode;
          ent_reg[i].func3  <= disp_func3;
          ent_reg[i].pc     <= disp_pc;
          ent_reg[i].imm    <= disp_imm;
          ent_reg[i].pd     <= disp_pd;
          ent_reg[i].ps1    <= disp_ps1;
          ent_reg[i].ps2    <= disp_ps2;
          ent_reg[i].rob    <= disp_rob;
        end else if (valid_reg[i]) begin
          if ((issued && (sel_idx == IW'(i))) || squash_vec[i]) begin
            valid_reg[i] <= 1'b0;
          end
          if (wb_hit1[i]) ps1_rdy_reg[i] <= 1'b1;
          if (wb_hit2[i]) ps2_rdy_reg[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_branch_sched.sv
// Directed testbench for rs_branch_sched: reset, basic issue, wakeup,
// wrapped age order, squash and dispatch blocking.
module tb_rs_branch_sched;

  logic        clk;
  logic        reset;
  logic        disp_valid;
  logic        disp_ready;
  logic [6:0]  disp_opcode;
  logic [2:0]  disp_func3;
  logic [31:0] disp_pc;
  logic [31:0] disp_imm;
  logic [6:0]  disp_pd;
  logic [6:0]  disp_ps1;
  logic [6:0]  disp_ps2;
  logic        disp_ps1_rdy;
  logic        disp_ps2_rdy;
  logic [4:0]  disp_rob;
  logic        wb_valid;
  logic [6:0]  wb_tag;
  logic [4:0]  rob_head;
  logic        fu_ready;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic        issued;
  logic [6:0]  iss_opcode;
  logic [2:0]  iss_func3;
  logic [31:0] iss_pc;
  logic [31:0] iss_imm;
  logic [6:0]  iss_pd;
  logic [6:0]  iss_ps1;
  logic [6:0]  iss_ps2;
  logic [4:0]  iss_rob;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  rs_branch_sched #(.DEPTH(4), .ROB_W(5), .PREG_W(7)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_func3(disp_func3),
    .disp_pc(disp_pc), .disp_imm(disp_imm),
    .disp_pd(disp_pd), .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
    .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
    .disp_rob(disp_rob),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .rob_head(rob_head), .fu_ready(fu_ready),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .issued(issued),
    .iss_opcode(iss_opcode), .iss_func3(iss_func3),
    .iss_pc(iss_pc), .iss_imm(iss_imm),
    .iss_pd(iss_pd), .iss_ps1(iss_ps1), .iss_ps2(iss_ps2),
    .iss_rob(iss_rob), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, checks 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Present a dispatch for one cycle (no check of acceptance here).
  task automatic dispatch(input logic [6:0] opc, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [4:0] rob,
                          input logic [6:0] p1, input logic r1,
                          input logic [6:0] p2, input logic r2);
    disp_opcode  = opc;
    disp_func3   = f3;
    disp_pc      = pc;
    disp_imm     = 32'd100;
    disp_pd      = 7'd10;
    disp_ps1     = p1;
    disp_ps1_rdy = r1;
    disp_ps2     = p2;
    disp_ps2_rdy = r2;
    disp_rob     = rob;
    disp_valid   = 1'b1;
    $display("txn dispatch pc=%0d rob=%0d ps1=%0d/%0b ps2=%0d/%0b", pc, rob, p1, r1, p2, r2);
    tick();
    disp_valid = 1'b0;
  endtask

  localparam logic [6:0] OP_BNE  = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  initial begin
    reset = 1'b1; disp_valid = 1'b0; disp_opcode = '0; disp_func3 = '0;
    disp_pc = '0; disp_imm = '0; disp_pd = '0; disp_ps1 = '0; disp_ps2 = '0;
    disp_ps1_rdy = 1'b0; disp_ps2_rdy = 1'b0; disp_rob = '0;
    wb_valid = 1'b0; wb_tag = '0; rob_head = '0; fu_ready = 1'b0;
    mispredict = 1'b0; mispredict_tag = '0;

    // Reset
    tick();
    reset = 1'b0;
    settle();
    $display("txn reset");
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_issued", 32'(issued), 32'd0);
    chk("rst_iss_pc", iss_pc, 32'd0);

    // Basic issue
    rob_head = 5'd10;
    fu_ready = 1'b1;
    dispatch(OP_BNE, 3'b001, 32'd2000, 5'd12, 7'd1, 1'b1, 7'd2, 1'b1);
    settle();
    chk("basic_issued", 32'(issued), 32'd1);
    chk("basic_pc", iss_pc, 32'd2000);
    chk("basic_rob", 32'(iss_rob), 32'd12);
    chk("basic_opcode", 32'(iss_opcode), 32'(OP_BNE));
    chk("basic_func3", 32'(iss_func3), 32'd1);
    chk("basic_imm", iss_imm, 32'd100);
    chk("basic_pd", 32'(iss_pd), 32'd10);
    chk("basic_ps2", 32'(iss_ps2), 32'd2);
    chk("basic_count1", 32'(count), 32'd1);
    tick();
    settle();
    chk("basic_count0", 32'(count), 32'd0);
    chk("basic_idle", 32'(issued), 32'd0);
    chk("basic_idle_pc", iss_pc, 32'd0);

    // Wakeup from the CDB; no same-cycle bypass into select
    dispatch(OP_JALR, 3'b000, 32'd3000, 5'd13, 7'd7, 1'b0, 7'd0, 1'b1);
    settle();
    chk("wake_wait", 32'(issued), 32'd0);
    chk("wake_count", 32'(count), 32'd1);
    wb_valid = 1'b1;
    wb_tag   = 7'd7;
    settle();
    $display("txn wakeup tag=7");
    chk("wake_nobypass", 32'(issued), 32'd0);
    tick();
    wb_valid = 1'b0;
    settle();
    chk("wake_issued", 32'(issued), 32'd1);
    chk("wake_ps1", 32'(iss_ps1), 32'd7);
    chk("wake_pc", iss_pc, 32'd3000);
    tick();
    settle();
    chk("wake_count0", 32'(count), 32'd0);

    // Wakeup arriving in the dispatch cycle is captured
    wb_valid = 1'b1;
    wb_tag   = 7'd9;
    dispatch(OP_BNE, 3'b001, 32'd3100, 5'd14, 7'd9, 1'b0, 7'd0, 1'b1);
    wb_valid = 1'b0;
    settle();
    chk("dispwake_issued", 32'(issued), 32'd1);
    chk("dispwake_pc", iss_pc, 32'd3100);
    tick();

    // Age order across ROB wrap
    rob_head = 5'd30;
    fu_ready = 1'b0;
    dispatch(OP_BNE, 3'b001, 32'd400, 5'd2, 7'd1, 1'b1, 7'd2, 1'b1);
    dispatch(OP_BNE, 3'b001, 32'd500, 5'd31, 7'd1, 1'b1, 7'd2, 1'b1);
    settle();
    chk("wrap_count", 32'(count), 32'd2);
    chk("wrap_hold", 32'(issued), 32'd0);
    fu_ready = 1'b1;
    settle();
    chk("wrap_first", 32'(iss_rob), 32'd31);
    chk("wrap_first_v", 32'(issued), 32'd1);
    tick();
    settle();
    chk("wrap_second", 32'(iss_rob), 32'd2);
    chk("wrap_second_pc", iss_pc, 32'd400);
    tick();
    settle();
    chk("wrap_empty", 32'(count), 32'd0);

    // Squash younger than mispredict; rob 4 is ready but mispredict blocks issue
    rob_head = 5'd0;
    fu_ready = 1'b0;
    dispatch(OP_BNE, 3'b001, 32'd604, 5'd4, 7'd1, 1'b1, 7'd2, 1'b1);
    dispatch(OP_BNE, 3'b001, 32'd606, 5'd6, 7'd20, 1'b0, 7'd2, 1'b1);
    dispatch(OP_BNE, 3'b001, 32'd609, 5'd9, 7'd21, 1'b0, 7'd2, 1'b1);
    settle();
    chk("sq_count3", 32'(count), 32'd3);
    mispredict     = 1'b1;
    mispredict_tag = 5'd5;
    fu_ready       = 1'b1;
    disp_valid     = 1'b1;
    disp_rob       = 5'd11;
    disp_ps1_rdy   = 1'b1;
    disp_ps2_rdy   = 1'b1;
    settle();
    $display("txn mispredict tag=5 with dispatch attempt");
    chk("sq_no_issue", 32'(issued), 32'd0);
    chk("sq_disp_block", 32'(disp_ready), 32'd0);
    tick();
    mispredict = 1'b0;
    disp_valid = 1'b0;
    fu_ready   = 1'b0;
    settle();
    chk("sq_count1", 32'(count), 32'd1);
    fu_ready = 1'b1;
    settle();
    chk("sq_survivor", 32'(iss_rob), 32'd4);
    tick();
    fu_ready = 1'b0;
    settle();
    chk("sq_empty", 32'(count), 32'd0);

    // Full RS blocks dispatch; same-cycle issue does not free a slot
    dispatch(OP_BNE, 3'b001, 32'd701, 5'd1, 7'd1, 1'b1, 7'd2, 1'b1);
    dispatch(OP_BNE, 3'b001, 32'd702, 5'd2, 7'd1, 1'b1, 7'd2, 1'b1);
    dispatch(OP_BNE, 3'b001, 32'd703, 5'd3, 7'd1, 1'b1, 7'd2, 1'b1);
    dispatch(OP_BNE, 3'b001, 32'd704, 5'd4, 7'd1, 1'b1, 7'd2, 1'b1);
    settle();
    chk("full_count4", 32'(count), 32'd4);
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    dispatch(OP_BNE, 3'b001, 32'd705, 5'd5, 7'd1, 1'b1, 7'd2, 1'b1);
    settle();
    chk("full_still4", 32'(count), 32'd4);
    fu_ready   = 1'b1;
    disp_valid = 1'b1;
    settle();
    chk("full_issue_oldest", 32'(iss_rob), 32'd1);
    chk("full_issue_noreuse", 32'(disp_ready), 32'd0);
    tick();
    disp_valid = 1'b0;
    fu_ready   = 1'b0;
    settle();
    chk("full_count3", 32'(count), 32'd3);

    // Equal-age entry survives its own mispredict
    mispredict     = 1'b1;
    mispredict_tag = 5'd2;
    $display("txn mispredict tag=2");
    tick();
    mispredict = 1'b0;
    settle();
    chk("eq_count1", 32'(count), 32'd1);
    fu_ready = 1'b1;
    settle();
    chk("eq_survivor", 32'(iss_rob), 32'd2);
    tick();
    settle();
    chk("eq_empty", 32'(count), 32'd0);
    chk("eq_idle", 32'(issued), 32'd0);

    // Reset mid-operation clears a pending entry
    fu_ready = 1'b0;
    dispatch(OP_BNE, 3'b001, 32'd800, 5'd6, 7'd1, 1'b1, 7'd2, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fu_ready = 1'b1;
    settle();
    $display("txn mid reset");
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_issued", 32'(issued), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
